// File: rtl/floating_argmax_stream_pkg.sv
// Shared FP32 field definitions, NaN predicate and argmax FSM state encoding.
package floating_argmax_stream_pkg;

  localparam int FP32_W   = 32;
  localparam int SIGN_BIT = 31;
  localparam int EXP_HI   = 30;
  localparam int EXP_LO   = 23;
  localparam int MANT_HI  = 22;
  localparam int MANT_LO  = 0;

  localparam logic [EXP_HI-EXP_LO:0] EXP_ALL_ONES = 8'hFF;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  function automatic logic is_nan(input logic [FP32_W-1:0] f);
    return (f[EXP_HI:EXP_LO] == EXP_ALL_ONES) && (f[MANT_HI:MANT_LO] != '0);
  endfunction

endpackage

// File: rtl/floating_argmax_stream_cmp.sv
// FloatingCompare: combinational A >= B over FP32 bit patterns using
// sign/exponent/mantissa ordering (+0 above -0, NaN/Inf ordered by raw bits).
module FloatingCompare
  import floating_argmax_stream_pkg::*;
(
  input  logic [FP32_W-1:0] a,
  input  logic [FP32_W-1:0] b,
  output logic              a_ge_b
);

  logic [FP32_W-1:0] ka, kb;

  // Map sign-magnitude onto an unsigned key: positives above negatives,
  // negatives ordered by inverted magnitude.
  always_comb begin
    ka = a[SIGN_BIT] ? {1'b0, ~a[SIGN_BIT-1:0]} : {1'b1, a[SIGN_BIT-1:0]};
    kb = b[SIGN_BIT] ? {1'b0, ~b[SIGN_BIT-1:0]} : {1'b1, b[SIGN_BIT-1:0]};
  end

  assign a_ge_b = (ka >= kb);

endmodule

// File: rtl/floating_argmax_stream.sv
// Streaming arg-max over N FP32 elements; result offered on valid/ready.
// Optional build macro FLOAT_ARGMAX_NAN_SKIP_EN: NaN never displaces a
// non-NaN max, and any non-NaN displaces a NaN max.
module floating_argmax_stream
  import floating_argmax_stream_pkg::*;
#(
  parameter int N     = 10,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FP32_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FP32_W-1:0] out_max,
  output logic [IDX_W-1:0]  out_idx
);

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   count;
  logic [FP32_W-1:0]  max_q;
  logic [IDX_W-1:0]   idx_q;
  logic               accept, last, max_ge_in, replace;

  FloatingCompare u_cmp (
    .a      (max_q),
    .b      (in_data),
    .a_ge_b (max_ge_in)
  );

  assign accept = in_valid & in_ready;
  assign last   = (count == IDX_W'(N - 1));

  // Decide whether the incoming element becomes the new running max.
  always_comb begin
    replace = 1'b0;
`ifdef FLOAT_ARGMAX_NAN_SKIP_EN
    if (count == '0)
      replace = 1'b1;
    else if (is_nan(max_q))
      replace = ~is_nan(in_data);
    else
      replace = ~is_nan(in_data) & ~max_ge_in;
`else
    replace = (count == '0) | ~max_ge_in;
`endif
  end

  // Next state and handshake outputs; input and output never both open.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (accept && last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  // Running max/index and element counter; only accepted beats move them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      max_q <= '0;
      idx_q <= '0;
    end else if (accept) begin
      count <= last ? '0 : count + IDX_W'(1);
      if (replace) begin
        max_q <= in_data;
        idx_q <= count;
      end
    end
  end

  assign out_max = max_q;
  assign out_idx = idx_q;

endmodule
